// File: rtl/occupancy_light_if.sv
// Signal bundle between the door-sensor/wall-switch side and the occupancy
// light controller.
interface occupancy_light_if #(
    parameter int CNT_W = 8
);
    logic             enter;
    logic             exit;
    logic             force_on;
    logic             force_off;
    logic             light;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output enter, exit, force_on, force_off,
        input  light, occupancy, full, ovf, unf
    );

    modport slave (
        input  enter, exit, force_on, force_off,
        output light, occupancy, full, ovf, unf
    );
endinterface

// File: rtl/occupancy_light_ctrl.sv
// Room-lighting controller: saturating head count from entry/exit pulses,
// light on while occupied plus an off-delay, with wall-switch overrides.
module occupancy_light_ctrl #(
    parameter int CNT_W     = 8,
    parameter int MAX_OCC   = 200,
    parameter int OFF_DELAY = 16,
    parameter int DLY_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    occupancy_light_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OCC);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [DLY_W-1:0] DLY_C  = DLY_W'(OFF_DELAY);
    localparam logic [DLY_W-1:0] T0_C   = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] T1_C   = DLY_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [DLY_W-1:0] timer_r;
    logic [DLY_W-1:0] timer_next_s;
    logic [CNT_W-1:0] occ_r;
    logic [CNT_W-1:0] occ_next_s;
    logic             ovf_next_s;
    logic             unf_next_s;
    logic             light_next_s;
    logic             light_r;
    logic             full_r;
    logic             ovf_r;
    logic             unf_r;

    // Saturating head-count update; dropped pulses raise ovf/unf for one cycle
    always_comb begin
        occ_next_s = occ_r;
        ovf_next_s = 1'b0;
        unf_next_s = 1'b0;
        if (bus.enter && !bus.exit) begin
            if (occ_r < MAX_C) begin
                occ_next_s = occ_r + ONE_C;
            end else begin
                ovf_next_s = 1'b1;
            end
        end else if (bus.exit && !bus.enter) begin
            if (occ_r > ZERO_C) begin
                occ_next_s = occ_r - ONE_C;
            end else begin
                unf_next_s = 1'b1;
            end
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Lighting FSM; decisions use the new count so the light follows on the same edge
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        case (state_r)
            ST_OFF: begin
                if (occ_next_s != ZERO_C) begin
                    state_next_s = ST_ON;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            ST_ON: begin
                if (occ_next_s == ZERO_C) begin
                    if (OFF_DELAY == 0) begin
                        state_next_s = ST_OFF;
                        timer_next_s = T0_C;
                    end else begin
                        state_next_s = ST_HOLD;
                        timer_next_s = DLY_C;
                    end
                end else begin
                    state_next_s = ST_ON;
                end
            end
            ST_HOLD: begin
                if (occ_next_s != ZERO_C) begin
                    state_next_s = ST_ON;
                    timer_next_s = T0_C;
                end else if (timer_r == T1_C) begin
                    state_next_s = ST_OFF;
                    timer_next_s = T0_C;
                end else begin
                    timer_next_s = timer_r - T1_C;
                end
            end
            default: begin
                state_next_s = ST_OFF;
                timer_next_s = T0_C;
            end
        endcase
    end

    // Overrides only mask the light; the FSM keeps tracking underneath
    always_comb begin
        if (bus.force_off) begin
            light_next_s = 1'b0;
        end else if (bus.force_on) begin
            light_next_s = 1'b1;
        end else begin
            light_next_s = (state_next_s != ST_OFF);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
            timer_r <= T0_C;
            occ_r   <= ZERO_C;
            light_r <= 1'b0;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            occ_r   <= occ_next_s;
            light_r <= light_next_s;
            full_r  <= (occ_next_s == MAX_C);
            ovf_r   <= ovf_next_s;
            unf_r   <= unf_next_s;
        end
    end

    assign bus.light     = light_r;
    assign bus.occupancy = occ_r;
    assign bus.full      = full_r;
    assign bus.ovf       = ovf_r;
    assign bus.unf       = unf_r;

endmodule

// File: tb/tb_occupancy_light_ctrl.sv
// Self-checking bench for occupancy_light_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a count model.
module tb_occupancy_light_ctrl;

    localparam int CNT_W     = 8;
    localparam int MAX_OCC   = 3;
    localparam int OFF_DELAY = 16;
    localparam int DLY_W     = 5;
    localparam int BIG       = 100000;

    logic clk;
    logic rst;

    occupancy_light_if #(.CNT_W(CNT_W)) bus ();

    occupancy_light_ctrl #(
        .CNT_W(CNT_W), .MAX_OCC(MAX_OCC), .OFF_DELAY(OFF_DELAY), .DLY_W(DLY_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: light is on while anyone is inside or fewer than
    // OFF_DELAY edges have passed since the room emptied.
    int m_occ, m_empty, m_light, m_full, m_ovf, m_unf;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int n, e, on;
        if (rst) begin
            m_occ <= 0; m_empty <= BIG; m_light <= 0;
            m_full <= 0; m_ovf <= 0; m_unf <= 0; m_valid <= 1'b1;
        end else begin
            n = m_occ;
            m_ovf <= 0;
            m_unf <= 0;
            if (bus.enter && !bus.exit) begin
                if (m_occ == MAX_OCC) m_ovf <= 1; else n = m_occ + 1;
            end else if (bus.exit && !bus.enter) begin
                if (m_occ == 0) m_unf <= 1; else n = m_occ - 1;
            end
            if (n > 0) e = -1;
            else if (m_empty == -1) e = 0;
            else if (m_empty >= BIG) e = BIG;
            else e = m_empty + 1;
            on = (n > 0) || (e >= 0 && e < OFF_DELAY);
            m_occ   <= n;
            m_empty <= e;
            m_full  <= (n == MAX_OCC);
            m_light <= bus.force_off ? 0 : (bus.force_on ? 1 : on);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_occupancy", int'(bus.occupancy), m_occ);
            chk("model_light", int'(bus.light), m_light);
            chk("model_full", int'(bus.full), m_full);
            chk("model_ovf", int'(bus.ovf), m_ovf);
            chk("model_unf", int'(bus.unf), m_unf);
        end
    end

    task automatic cyc(input logic e, input logic x);
        bus.enter = e;
        bus.exit  = x;
        @(posedge clk);
        #1;
        bus.enter = 1'b0;
        bus.exit  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.enter = 1'b0; bus.exit = 1'b0;
        bus.force_on = 1'b0; bus.force_off = 1'b0;
        #2;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        chk("reset_occ", int'(bus.occupancy), 0);
        chk("reset_light", int'(bus.light), 0);
        chk("reset_full", int'(bus.full), 0);

        // Entry/exit latency and the off-delay
        cyc(1'b1, 1'b0);
        chk("enter_occ", int'(bus.occupancy), 1);
        chk("enter_light", int'(bus.light), 1);
        cyc(1'b0, 1'b1);
        chk("exit_occ", int'(bus.occupancy), 0);
        chk("exit_light", int'(bus.light), 1);
        idle(15);
        chk("delay_15_light", int'(bus.light), 1);
        idle(1);
        chk("delay_16_light", int'(bus.light), 0);

        // Underflow
        cyc(1'b0, 1'b1);
        chk("unf_occ", int'(bus.occupancy), 0);
        chk("unf_flag", int'(bus.unf), 1);
        chk("unf_light", int'(bus.light), 0);
        idle(1);
        chk("unf_clear", int'(bus.unf), 0);

        // Saturation at MAX_OCC
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("sat3_full", int'(bus.full), 1);
        chk("sat3_ovf", int'(bus.ovf), 0);
        cyc(1'b1, 1'b0);
        chk("sat4_occ", int'(bus.occupancy), 3);
        chk("sat4_ovf", int'(bus.ovf), 1);
        idle(1);
        chk("ovf_clear", int'(bus.ovf), 0);

        // Simultaneous enter and exit
        cyc(1'b0, 1'b1);
        chk("dec_full", int'(bus.full), 0);
        cyc(1'b1, 1'b1);
        chk("both_occ", int'(bus.occupancy), 2);
        chk("both_flags", int'(bus.ovf) + int'(bus.unf), 0);

        // Re-entry during HOLD restarts the whole delay
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        idle(11);
        cyc(1'b1, 1'b0);
        chk("reentry_light", int'(bus.light), 1);
        cyc(1'b0, 1'b1);
        idle(15);
        chk("redelay_15_light", int'(bus.light), 1);
        idle(1);
        chk("redelay_16_light", int'(bus.light), 0);

        // Overrides
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        bus.force_off = 1'b1;
        cyc(1'b1, 1'b0);
        chk("foff_light", int'(bus.light), 0);
        chk("foff_occ", int'(bus.occupancy), 3);
        bus.force_on = 1'b1;
        cyc(1'b0, 1'b1);
        chk("foff_beats_fon", int'(bus.light), 0);
        bus.force_on = 1'b0;
        bus.force_off = 1'b0;
        idle(1);
        chk("foff_release", int'(bus.light), 1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        idle(20);
        bus.force_on = 1'b1;
        idle(1);
        chk("fon_empty_light", int'(bus.light), 1);
        bus.force_on = 1'b0;
        idle(1);
        chk("fon_release", int'(bus.light), 0);

        // Reset mid-HOLD with an override active
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        idle(3);
        bus.force_on = 1'b1;
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        rst = 1'b0;
        chk("rst_hold_light", int'(bus.light), 0);
        chk("rst_hold_occ", int'(bus.occupancy), 0);
        bus.force_on = 1'b0;
        idle(1);
        chk("after_rst_light", int'(bus.light), 0);

        // Randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            bus.force_on  = ($urandom_range(0, 19) == 0);
            bus.force_off = ($urandom_range(0, 29) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 99) == 0) idle(OFF_DELAY + 2);
        end
        rst = 1'b0;
        bus.force_on = 1'b0;
        bus.force_off = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
